// File: rtl/axi_pkg.sv
// Shared AXI channel types and constants for the memory responder.
// The request bundle carries the AW, W and AR channels; the response bundle carries the readies plus B and R.
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

    typedef struct packed {
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arvalid;
    } axi_request_t;

    typedef struct packed {
        logic [1:0] bresp;
        logic       bvalid;
    } axi_b_response_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
    } axi_r_response_t;

    typedef struct packed {
        logic            awready;
        logic            wready;
        logic            arready;
        axi_b_response_t b;
        axi_r_response_t r;
    } axi_response_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Only 4-byte INCR bursts are serviced; anything else completes with SLVERR.
    function automatic logic ax_error(input logic [2:0] size, input logic [1:0] burst);
        return (size != AXI_SIZE_4B) || (burst != AXI_BURST_INCR);
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// DEPTH x 32 storage: one byte-enabled write port and one registered read port.
// A read and write to the same word in the same cycle returns the old contents.
module axi_mem_array #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    // One narrow array per byte lane so each lane maps to its own block RAM column.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] rd_reg;

        always_ff @(posedge clk) begin
            if (we[gi]) begin
                lane_mem[waddr] <= wdata[gi*8 +: 8];
            end
            if (re) begin
                rd_reg <= lane_mem[raddr];
            end
        end

        assign rdata[gi*8 +: 8] = rd_reg;
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI subordinate backed by word-addressed memory: one write and one read burst in flight,
// INCR with 4-byte beats, with fully independent write and read FSMs.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  axi_request_t  req,
    input  logic          bready,
    input  logic          rready,
    output axi_response_t rsp
);

    localparam int IW = $clog2(DEPTH);

    w_state_t        w_state_reg, w_state_next;
    logic [IW-1:0]   w_idx_reg, w_idx_next;
    logic [7:0]      w_len_reg, w_len_next;
    logic [7:0]      w_cnt_reg, w_cnt_next;
    logic            w_err_reg, w_err_next;

    r_state_t        r_state_reg, r_state_next;
    logic [IW-1:0]   r_idx_reg, r_idx_next;
    logic [7:0]      r_len_reg, r_len_next;
    logic [7:0]      r_cnt_reg, r_cnt_next;
    logic            r_err_reg, r_err_next;

    logic [3:0]      mem_we;
    logic            mem_re;
    logic [IW-1:0]   mem_raddr;
    logic [31:0]     mem_rdata;
    logic            w_final_beat;
    logic            r_final_beat;

    assign w_final_beat = (w_cnt_reg == w_len_reg);
    assign r_final_beat = (r_cnt_reg == r_len_reg);

    axi_mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (w_idx_reg),
        .wdata (req.wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_reg <= W_IDLE;
            w_idx_reg   <= '0;
            w_len_reg   <= '0;
            w_cnt_reg   <= '0;
            w_err_reg   <= 1'b0;
            r_state_reg <= R_IDLE;
            r_idx_reg   <= '0;
            r_len_reg   <= '0;
            r_cnt_reg   <= '0;
            r_err_reg   <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            w_idx_reg   <= w_idx_next;
            w_len_reg   <= w_len_next;
            w_cnt_reg   <= w_cnt_next;
            w_err_reg   <= w_err_next;
            r_state_reg <= r_state_next;
            r_idx_reg   <= r_idx_next;
            r_len_reg   <= r_len_next;
            r_cnt_reg   <= r_cnt_next;
            r_err_reg   <= r_err_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        w_idx_next   = w_idx_reg;
        w_len_next   = w_len_reg;
        w_cnt_next   = w_cnt_reg;
        w_err_next   = w_err_reg;
        mem_we       = 4'b0000;
        case (w_state_reg)
            W_IDLE: begin
                if (req.awvalid) begin
                    w_idx_next   = req.awaddr[IW+1:2];
                    w_len_next   = req.awlen;
                    w_cnt_next   = '0;
                    w_err_next   = ax_error(req.awsize, req.awburst);
                    w_state_next = W_DATA;
                end
            end
            W_DATA: begin
                if (req.wvalid) begin
                    // A wlast mismatch flags the burst but does not undo this or earlier beats.
                    mem_we       = w_err_reg ? 4'b0000 : req.wstrb;
                    w_err_next   = w_err_reg | (req.wlast != w_final_beat);
                    w_idx_next   = w_idx_reg + IW'(1);
                    w_cnt_next   = w_cnt_reg + 8'd1;
                    if (w_final_beat) begin
                        w_state_next = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state_reg;
        r_idx_next   = r_idx_reg;
        r_len_next   = r_len_reg;
        r_cnt_next   = r_cnt_reg;
        r_err_next   = r_err_reg;
        mem_re       = 1'b0;
        mem_raddr    = r_idx_reg + IW'(1);
        case (r_state_reg)
            R_IDLE: begin
                mem_raddr = req.araddr[IW+1:2];
                if (req.arvalid) begin
                    mem_re       = 1'b1;
                    r_idx_next   = req.araddr[IW+1:2];
                    r_len_next   = req.arlen;
                    r_cnt_next   = '0;
                    r_err_next   = ax_error(req.arsize, req.arburst);
                    r_state_next = R_DATA;
                end
            end
            R_DATA: begin
                // The read register only reloads on acceptance, so a stalled beat stays put.
                if (rready) begin
                    if (r_final_beat) begin
                        r_state_next = R_IDLE;
                    end else begin
                        mem_re     = 1'b1;
                        r_idx_next = r_idx_reg + IW'(1);
                        r_cnt_next = r_cnt_reg + 8'd1;
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        rsp           = '0;
        rsp.awready   = (w_state_reg == W_IDLE);
        rsp.wready    = (w_state_reg == W_DATA);
        rsp.arready   = (r_state_reg == R_IDLE);
        rsp.b.bvalid  = (w_state_reg == W_RESP);
        rsp.b.bresp   = (w_state_reg == W_RESP && w_err_reg) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rsp.r.rvalid  = (r_state_reg == R_DATA);
        rsp.r.rlast   = (r_state_reg == R_DATA) && r_final_beat;
        rsp.r.rresp   = (r_state_reg == R_DATA && r_err_reg) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rsp.r.rdata   = (r_state_reg == R_DATA && !r_err_reg) ? mem_rdata : 32'h0;
    end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI subordinate that terminates the manager request channels (`axi_request_t`: AW, W, AR) and returns the matching ready, write-response and read-data signals. It is backed by a word-addressed memory. It sits at the far end of the CPU's AXI port, as the default memory target for simulation and small on-chip RAM. It supports one outstanding write burst and one outstanding read burst, both INCR with 4-byte beats, and the two directions run independently.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; must be a power of two.
- `clk` input 1: clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input `axi_request_t`: AW, W and AR channel payloads and valids from the manager.
- `bready` input 1: manager accepts the write response.
- `rready` input 1: manager accepts the read beat.
- `rsp` output `axi_response_t`: contains the following fields.
  - `awready`, `wready`, `arready`.
  - `bvalid`, `bresp[1:0]`.
  - `rvalid`, `rdata[31:0]`, `rresp[1:0]`, `rlast`.

## Operation
- **Word index:** `addr[2+$clog2(DEPTH)-1:2]`.
  - Upper bits are ignored, so accesses alias modulo DEPTH.
  - The index increments by 1 per beat and wraps from DEPTH-1 to 0.
- **Write FSM, `W_IDLE`:** `awready`=1.
  - On `awvalid`, latch the address, `awlen` and the error flag.
  - The error flag is set when `awsize`≠3'b010 or `awburst`≠2'b01.
  - Next state is `W_DATA`.
- **Write FSM, `W_DATA`:** `wready`=1.
  - On each `wvalid` beat, write the bytes selected by `wstrb` to memory. The write is suppressed when the error flag is set.
  - Increment the index and the beat count.
  - A `wlast` mismatch sets the error flag. Mismatch means `wlast`=1 on a non-final beat, or `wlast`=0 on the final beat. Beats already written stay written.
  - After beat `awlen`+1, go to `W_RESP`.
- **Write FSM, `W_RESP`:** `bvalid`=1; `bresp` = OKAY 2'b00, or SLVERR 2'b10 if the error flag is set.
  - Hold until `bready`, then return to `W_IDLE`.
- **Read FSM, `R_IDLE`:** `arready`=1.
  - On `arvalid`, latch the state and the error flag, using the same size/burst check as writes.
  - Load the `rdata` register from `mem[index]`, or 0 on error.
  - Next state is `R_DATA`.
- **Read FSM, `R_DATA`:** `rvalid`=1; `rlast`=1 on beat `arlen`+1; `rresp` = OKAY, or SLVERR on error.
  - On `rready`, advance the index and reload `rdata` with the next word.
  - After the last beat, return to `R_IDLE`.
- **Simultaneous write and read of the same word:** the read register samples the pre-write contents (old data).
- **Reset:**
  - Both FSMs go to IDLE and all counters and error flags clear.
  - `rdata`=0, `bresp`=`rresp`=0, `rlast`=0.
  - Memory contents are not reset.
- **Reset mid-burst:** the burst is abandoned with no response. Words already written remain.

## Timing
- **Ready signals:** decoded from FSM state.
  - Values in the first cycle after reset: `awready`=`arready`=1; `wready`=`bvalid`=`rvalid`=0.
- **Write path:**
  - AW handshake at edge t gives `wready`=1 from cycle t+1.
  - A final W beat at edge u gives `bvalid`=1 from cycle u+1.
  - W beats are accepted at 1 per cycle.
  - W beats presented before the AW handshake are not accepted (`wready`=0).
- **Read path:**
  - AR handshake at edge t gives `rvalid`=1 with the first word in cycle t+1.
  - Beats are delivered at 1 per cycle while `rready`=1.
  - With `rready`=0, `rvalid`, `rdata` and `rlast` hold stable.
- **Turnaround:** at least one cycle between bursts in each direction, because ready is only asserted in IDLE.
- **Independence:** read and write FSMs never stall each other.

## Structure
- **`axi_pkg`:** add `axi_response_t`, built from these channel structs:
  - `axi_b_response_t`: `bresp`, `bvalid`.
  - `axi_r_response_t`: `rdata`, `rresp`, `rlast`, `rvalid`.
  - Ready bits: `awready`, `wready`, `arready`.
- **Constants, also in `axi_pkg`:** `AXI_RESP_OKAY`=2'b00, `AXI_RESP_SLVERR`=2'b10, `AXI_BURST_INCR`=2'b01, `AXI_SIZE_4B`=3'b010.
- **Sub-module `axi_mem_array`:** DEPTH×32 storage with one byte-enabled write port and one synchronous read port. Both FSMs stay in `axi_mem_responder`.

## Test plan
- **Single write then read:** AW addr 0x10, len 0; W 0xDEADBEEF, strb 4'hF, wlast=1 → bresp OKAY. Then AR 0x10, len 0 → rdata 0xDEADBEEF, rlast=1, rresp OKAY.
- **4-beat INCR write and read:** write at 0x100, len 3, data 1..4 → read back 1,2,3,4 with rlast only on beat 4. Hold `rready`=0 for 3 cycles mid-burst → data holds stable.
- **Byte strobes:** write 0xFFFFFFFF, then 0x00000000 with strb 4'b0101 → read 0xFF00FF00.
- **Errors:**
  - AW with awsize 3'b001 → bresp SLVERR and memory unchanged.
  - AR with awburst-equivalent arburst 2'b10 → rresp SLVERR, rdata 0.
  - `wlast`=1 on beat 1 of len 3 → SLVERR after 4 beats.
- **Wrap and collision:**
  - Write len 1 at word DEPTH-1 → second beat lands at word 0.
  - Concurrent read and write to the same word in the same cycle → read returns old value.
- **Reset mid-burst:** `rst` during `W_DATA` → next cycle `awready`=1, `wready`=0, no `bvalid`. A new burst then completes normally.
